// File: rtl/alu_pkg.sv
// Shared types and constants for the DSP ALU datapath.
// Holds the serial adder state type, the nibble width and a helper
// that produces the signed saturation limits for a given operand width.
package alu_pkg;

    localparam int NIBBLE_W  = 4;

    // The saturation helper returns a fixed 64-bit value.
    // Callers truncate it to their own width, so widths up to 64 bits are covered.
    localparam int SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed two's-complement limit for a width-bit word:
    // negative=1 gives the most negative value, negative=0 gives the most positive value.
    function automatic logic [SAT_MAX_W-1:0] sat_value(input int width, input logic negative);
        logic [SAT_MAX_W-1:0] min_v;
        min_v = SAT_MAX_W'(1) << (width - 1);
        return negative ? min_v : (min_v - SAT_MAX_W'(1));
    endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// One 4-bit ripple-carry adder slice.
// The serial adder time-multiplexes this slice across all operand nibbles.
module nibble_add_slice
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] carry;

    // Explicit ripple chain: each bit generates a sum and passes its carry upward.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract unit.
// It processes one nibble per cycle through a single shared slice,
// starting with the least significant nibble.
// Operands enter and results leave over valid/ready handshakes.
// Optional build macro SERIAL_ADDER_SAT_EN:
//   When defined, a result that overflows is replaced by the signed saturation value.
module nibble_serial_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int                NIBBLES  = WIDTH / NIBBLE_W;
    localparam int                CNT_W    = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NIBBLES - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_cout;
    logic                load;

    assign slice_a = a_q[NIBBLE_W*cnt_q +: NIBBLE_W];
    assign slice_b = b_q[NIBBLE_W*cnt_q +: NIBBLE_W];

    nibble_add_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Next-state, datapath update and handshake outputs.
    // B is stored pre-inverted for subtraction, so RUN only ever adds.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load = 1'b1;
                end
            end
            RUN: begin
                sum_d[NIBBLE_W*cnt_q +: NIBBLE_W] = slice_s;
                carry_d = slice_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    cout_d  = slice_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (slice_s[NIBBLE_W-1] != a_q[WIDTH-1]);
`ifdef SERIAL_ADDER_SAT_EN
                    if (ovf_d) begin
                        sum_d = WIDTH'(sat_value(WIDTH, a_q[WIDTH-1]));
                    end
`endif
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            a_d     = a;
            b_d     = b ^ {WIDTH{sub}};
            carry_d = sub | cin;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    // State and datapath registers.
    // Reset aborts any operation in flight and clears the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
